// File: rtl/cpu_mul_pkg.sv
// Shared types and default sizing for the execute-stage multiplier.
// REG_WIDTH / NUM_REGS defines, when present, set the default operand width and register count.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

`ifndef NUM_REGS
`define NUM_REGS 16
`endif

package cpu_mul_pkg;

  localparam int unsigned MUL_REG_WIDTH = `REG_WIDTH;
  localparam int unsigned MUL_NUM_REGS  = `NUM_REGS;

  localparam int unsigned MUL_ID_WIDTH = $clog2(MUL_NUM_REGS);

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHU  = 2'd2,
    MULHSU = 2'd3
  } mul_mode_t;

  // Reference stage layout at the default sizing; the top rebuilds it from its own parameters.
  typedef struct packed {
    logic                       valid;
    logic [MUL_ID_WIDTH-1:0]    rd_id;
    mul_mode_t                  mode;
    logic [2*MUL_REG_WIDTH-1:0] product;
  } mul_stage_t;

endpackage

// File: rtl/cpu_mul_stage.sv
// One multiplier pipeline register: valid bit plus opaque payload.
// Flush beats stall; payload may keep stale contents when invalid.
module cpu_mul_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/cpu_mul_pipeline.sv
// Valid-tagged pipelined multiplier with stall/flush and pending-destination mask.
// CPU_MUL_HIGH_EN enables the high-half modes and the full 2*WIDTH product.
module cpu_mul_pipeline
    import cpu_mul_pkg::*;
#(
    parameter int unsigned WIDTH    = MUL_REG_WIDTH,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned NUM_REGS = MUL_NUM_REGS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [$clog2(NUM_REGS)-1:0] in_rd_id,
    input  logic [WIDTH-1:0]            in_ra,
    input  logic [WIDTH-1:0]            in_rb,
    input  logic [1:0]                  in_mode,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        wb_valid,
    output logic [$clog2(NUM_REGS)-1:0] wb_rd_id,
    output logic [WIDTH-1:0]            wb_data,
    output logic [NUM_REGS-1:0]         pending_mask,
    output logic                        busy
);

    localparam int unsigned IDW = $clog2(NUM_REGS);

`ifdef CPU_MUL_HIGH_EN
    localparam int unsigned PW = 2 * WIDTH;
    typedef struct packed {
        logic [IDW-1:0] rd_id;
        mul_mode_t      mode;
        logic [PW-1:0]  product;
    } payload_t;
`else
    localparam int unsigned PW = WIDTH;
    typedef struct packed {
        logic [IDW-1:0] rd_id;
        logic [PW-1:0]  product;
    } payload_t;
`endif

    localparam int unsigned PLW = $bits(payload_t);

    // Index 0 is the issue side; index i (1..STAGES) is the output of stage i-1.
    logic     stage_valid   [STAGES+1];
    payload_t stage_payload [STAGES+1];
    payload_t last;

`ifdef CPU_MUL_HIGH_EN
    mul_mode_t     mode_in;
    logic          sign_a;
    logic          sign_b;
    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;

    assign mode_in = mul_mode_t'(in_mode);

    // Sign-extending to 2*WIDTH makes one unsigned multiply serve all four modes.
    always_comb begin
        sign_a = (mode_in == MULH) || (mode_in == MULHSU);
        sign_b = (mode_in == MULH);
        ext_a  = {{WIDTH{sign_a & in_ra[WIDTH-1]}}, in_ra};
        ext_b  = {{WIDTH{sign_b & in_rb[WIDTH-1]}}, in_rb};
        stage_payload[0].rd_id   = in_rd_id;
        stage_payload[0].mode    = mode_in;
        stage_payload[0].product = ext_a * ext_b;
    end
`else
    logic unused_mode;
    assign unused_mode = ^in_mode;

    always_comb begin
        stage_payload[0].rd_id   = in_rd_id;
        stage_payload[0].product = in_ra * in_rb;
    end
`endif

    assign stage_valid[0] = in_valid;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cpu_mul_stage #(
            .W (PLW)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .stall     (stall),
            .flush     (flush),
            .in_valid  (stage_valid[i]),
            .in_data   (stage_payload[i]),
            .out_valid (stage_valid[i+1]),
            .out_data  (stage_payload[i+1])
        );
    end

    assign last     = stage_payload[STAGES];
    assign wb_valid = stage_valid[STAGES];
    assign wb_rd_id = last.rd_id;

`ifdef CPU_MUL_HIGH_EN
    assign wb_data = (last.mode == MUL) ? last.product[WIDTH-1:0] : last.product[PW-1:WIDTH];
`else
    assign wb_data = last.product;
`endif

    always_comb begin
        pending_mask = '0;
        busy         = 1'b0;
        for (int unsigned i = 1; i <= STAGES; i++) begin
            if (stage_valid[i]) begin
                pending_mask[stage_payload[i].rd_id] = 1'b1;
                busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mul_pipeline.sv
// Directed bench for cpu_mul_pipeline at WIDTH=16, STAGES=3, NUM_REGS=16.
// Expectations adapt to whether CPU_MUL_HIGH_EN is defined.
module tb_cpu_mul_pipeline;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_rd_id;
    logic [15:0] in_ra;
    logic [15:0] in_rb;
    logic [1:0]  in_mode;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_rd_id;
    logic [15:0] wb_data;
    logic [15:0] pending_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cpu_mul_pipeline #(
        .WIDTH    (16),
        .STAGES   (3),
        .NUM_REGS (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_rd_id     (in_rd_id),
        .in_ra        (in_ra),
        .in_rb        (in_rb),
        .in_mode      (in_mode),
        .stall        (stall),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_rd_id     (wb_rd_id),
        .wb_data      (wb_data),
        .pending_mask (pending_mask),
        .busy         (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] rd, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m);
        in_valid = 1'b1;
        in_rd_id = rd;
        in_ra    = a;
        in_rb    = b;
        in_mode  = m;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_rd_id = '0;
        in_ra    = '0;
        in_rb    = '0;
        in_mode  = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_mask"}, {16'd0, pending_mask}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        #12;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_rd", {28'd0, wb_rd_id}, 32'd0);
        check("rst_wb_data", {16'd0, wb_data}, 32'd0);
        check("rst_mask", {16'd0, pending_mask}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic mode-0 latency and pending window.
        issue(4'd4, 16'h0003, 16'h0005, 2'd0);
        tick();
        idle();
        check("lat_c1_wb", {31'd0, wb_valid}, 32'd0);
        check("lat_c1_mask", {16'd0, pending_mask}, 32'h0010);
        tick();
        check("lat_c2_wb", {31'd0, wb_valid}, 32'd0);
        check("lat_c2_mask", {16'd0, pending_mask}, 32'h0010);
        tick();
        check("lat_c3_wb", {31'd0, wb_valid}, 32'd1);
        check("lat_c3_rd", {28'd0, wb_rd_id}, 32'd4);
        check("lat_c3_data", {16'd0, wb_data}, 32'h000F);
        check("lat_c3_mask", {16'd0, pending_mask}, 32'h0010);
        tick();
        check_quiet("lat_c4");

        // Back-to-back high modes.
        issue(4'd1, 16'hFFFF, 16'h0002, 2'd1);
        tick();
        issue(4'd2, 16'hFFFF, 16'h0002, 2'd2);
        tick();
        issue(4'd3, 16'hFFFF, 16'h0002, 2'd3);
        tick();
        idle();
        check("b2b_mask", {16'd0, pending_mask}, 32'h000E);
        check("b2b1_wb", {31'd0, wb_valid}, 32'd1);
        check("b2b1_rd", {28'd0, wb_rd_id}, 32'd1);
`ifdef CPU_MUL_HIGH_EN
        check("b2b1_data", {16'd0, wb_data}, 32'hFFFF);
`else
        check("b2b1_data", {16'd0, wb_data}, 32'hFFFE);
`endif
        tick();
        check("b2b2_wb", {31'd0, wb_valid}, 32'd1);
        check("b2b2_rd", {28'd0, wb_rd_id}, 32'd2);
`ifdef CPU_MUL_HIGH_EN
        check("b2b2_data", {16'd0, wb_data}, 32'h0001);
`else
        check("b2b2_data", {16'd0, wb_data}, 32'hFFFE);
`endif
        tick();
        check("b2b3_wb", {31'd0, wb_valid}, 32'd1);
        check("b2b3_rd", {28'd0, wb_rd_id}, 32'd3);
`ifdef CPU_MUL_HIGH_EN
        check("b2b3_data", {16'd0, wb_data}, 32'hFFFF);
`else
        check("b2b3_data", {16'd0, wb_data}, 32'hFFFE);
`endif
        tick();
        check_quiet("b2b_end");

        // Stall two cycles with the op in stage 1; in_valid during stall is dropped.
        issue(4'd5, 16'h0007, 16'h0006, 2'd0);
        tick();
        idle();
        tick();
        stall = 1'b1;
        issue(4'd9, 16'h0011, 16'h0011, 2'd0);
        tick();
        check("stl_c3_wb", {31'd0, wb_valid}, 32'd0);
        check("stl_c3_mask", {16'd0, pending_mask}, 32'h0020);
        tick();
        check("stl_c4_wb", {31'd0, wb_valid}, 32'd0);
        stall = 1'b0;
        idle();
        tick();
        check("stl_c5_wb", {31'd0, wb_valid}, 32'd1);
        check("stl_c5_rd", {28'd0, wb_rd_id}, 32'd5);
        check("stl_c5_data", {16'd0, wb_data}, 32'h002A);
        check("stl_c5_mask", {16'd0, pending_mask}, 32'h0020);
        stall = 1'b1;
        tick();
        check("stl_hold_wb", {31'd0, wb_valid}, 32'd1);
        check("stl_hold_data", {16'd0, wb_data}, 32'h002A);
        stall = 1'b0;
        tick();
        check_quiet("stl_end");

        // Flush together with stall and a new in_valid.
        issue(4'd1, 16'h0002, 16'h0003, 2'd0);
        tick();
        issue(4'd2, 16'h0004, 16'h0005, 2'd0);
        tick();
        check("fl_pre_mask", {16'd0, pending_mask}, 32'h0006);
        check("fl_pre_busy", {31'd0, busy}, 32'd1);
        issue(4'd3, 16'h0006, 16'h0007, 2'd0);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        idle();
        check_quiet("fl_c1");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fl_no_wb", {31'd0, wb_valid}, 32'd0);
        end

        // Asynchronous reset with three ops in flight.
        issue(4'd6, 16'h0002, 16'h0002, 2'd0);
        tick();
        issue(4'd7, 16'h0003, 16'h0003, 2'd0);
        tick();
        issue(4'd8, 16'h0004, 16'h0004, 2'd0);
        tick();
        idle();
        check("ar_pre_wb", {31'd0, wb_valid}, 32'd1);
        check("ar_pre_data", {16'd0, wb_data}, 32'h0004);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("ar_now");
        check("ar_now_data", {16'd0, wb_data}, 32'd0);
        check("ar_now_rd", {28'd0, wb_rd_id}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ar_no_wb", {31'd0, wb_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
